// File: rtl/mux_pkg.sv
// Shared types and helpers for the stream multiplexer.
package mux_pkg;

  typedef enum logic {
    MODE_SEL = 1'b0,
    MODE_RR  = 1'b1
  } mode_e;

  // Index width that stays at least one bit wide, even for tiny channel counts.
  function automatic int unsigned clog2_safe(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_mux_if.sv
// Handshake bundle between a set of producers, the mux and one consumer.
interface stream_mux_if
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N_IN  = 4,
  parameter int unsigned SEL_W = clog2_safe(N_IN)
);

  mode_e                   mode;
  logic [SEL_W-1:0]        sel;
  logic [N_IN*WIDTH-1:0]   in_data;
  logic [N_IN-1:0]         in_valid;
  logic [N_IN-1:0]         in_ready;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_src;
  logic                    out_valid;
  logic                    out_ready;

  // Environment side: drives the channels and the downstream ready.
  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_src, out_valid
  );

  // Mux side.
  modport slave (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_src, out_valid
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first requester at or above ptr, wrapping at N-1.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = clog2_safe(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_vld
);

  logic [IDX_W:0] w_cand;

  always_comb begin
    grant_idx = '0;
    grant_vld = 1'b0;
    w_cand    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_cand = {1'b0, ptr} + (IDX_W + 1)'(k);
      // Explicit wrap so non power-of-two N never lands on an unused index.
      if (w_cand >= (IDX_W + 1)'(N)) begin
        w_cand = w_cand - (IDX_W + 1)'(N);
      end
      if (!grant_vld && req[w_cand[IDX_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = w_cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/stream_mux.sv
// N-channel registered stream mux: explicit select or round-robin, one-entry output register.
module stream_mux
  import mux_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned N_IN  = 4,
  localparam int unsigned SEL_W = clog2_safe(N_IN)
) (
  input  logic         clk,
  input  logic         rst_n,
  stream_mux_if.slave  bus
);

  logic [SEL_W-1:0]      r_ptr;
  logic [SEL_W-1:0]      r_src;
  logic [WIDTH-1:0]      r_data;
  logic                  r_valid;

  logic                  w_can_load;
  logic [SEL_W-1:0]      w_rr_idx;
  logic                  w_rr_vld;
  logic [2**SEL_W-1:0]   w_valid_pad;
  logic                  w_sel_vld;
  logic [SEL_W-1:0]      w_grant_idx;
  logic                  w_grant_vld;
  logic                  w_load;
  logic [WIDTH-1:0]      w_grant_data;
  logic [SEL_W-1:0]      w_ptr_next;

  rr_arbiter #(
    .N     (N_IN),
    .IDX_W (SEL_W)
  ) u_rr_arbiter (
    .req       (bus.in_valid),
    .ptr       (r_ptr),
    .grant_idx (w_rr_idx),
    .grant_vld (w_rr_vld)
  );

  assign w_can_load  = !r_valid || bus.out_ready;

  // Zero-padded so an out-of-range sel reads a 0 instead of indexing past the vector.
  assign w_valid_pad = (2**SEL_W)'(bus.in_valid);
  assign w_sel_vld   = (32'(bus.sel) < N_IN) && w_valid_pad[bus.sel];

  always_comb begin
    w_grant_idx = '0;
    w_grant_vld = 1'b0;
    case (bus.mode)
      MODE_SEL: begin
        w_grant_idx = bus.sel;
        w_grant_vld = w_sel_vld;
      end
      MODE_RR: begin
        w_grant_idx = w_rr_idx;
        w_grant_vld = w_rr_vld;
      end
      default: begin
        w_grant_idx = '0;
        w_grant_vld = 1'b0;
      end
    endcase
  end

  assign w_load       = rst_n && w_can_load && w_grant_vld;
  assign w_grant_data = bus.in_data[32'(w_grant_idx) * WIDTH +: WIDTH];
  assign w_ptr_next   = (32'(w_grant_idx) == N_IN - 1) ? '0 : w_grant_idx + SEL_W'(1);

  always_comb begin
    bus.in_ready = '0;
    if (w_load) begin
      bus.in_ready[w_grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr   <= '0;
      r_src   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_load) begin
        r_data  <= w_grant_data;
        r_src   <= w_grant_idx;
        r_valid <= 1'b1;
        if (bus.mode == MODE_RR) begin
          r_ptr <= w_ptr_next;
        end
      end else if (bus.out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.out_data  = r_data;
  assign bus.out_src   = r_src;
  assign bus.out_valid = r_valid;

endmodule

// File: tb/tb_stream_mux.sv
// Directed checks on a 4-channel mux plus a randomized scoreboard run on a 3-channel mux.
module tb_stream_mux;
  import mux_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  stream_mux_if #(.WIDTH(8), .N_IN(4)) b4 ();
  stream_mux_if #(.WIDTH(8), .N_IN(3)) b3 ();

  stream_mux #(.WIDTH(8), .N_IN(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));
  stream_mux #(.WIDTH(8), .N_IN(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(b3.slave));

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model state for the 3-channel run.
  int          m_ptr;
  bit          m_ov;
  logic [31:0] exp_q[$];
  int          wait_cnt[3];

  initial begin
    int          exp_src[3];
    bit          can, gv;
    int          gi, c;
    logic [31:0] exp_rdy, front, beat;
    logic [7:0]  dat;

    rst_n = 1'b0;
    b4.mode = MODE_SEL; b4.sel = '0; b4.in_data = '0; b4.in_valid = '0; b4.out_ready = 1'b0;
    b3.mode = MODE_SEL; b3.sel = '0; b3.in_data = '0; b3.in_valid = '0; b3.out_ready = 1'b0;
    #1;
    check("rst_ov", b4.out_valid, 0);
    check("rst_od", b4.out_data, 0);
    check("rst_os", b4.out_src, 0);
    check("rst_rdy", b4.in_ready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Explicit select, channel 2.
    @(negedge clk);
    b4.mode = MODE_SEL; b4.sel = 2'd2; b4.in_valid = 4'b0100;
    b4.in_data = {8'h44, 8'hA5, 8'h22, 8'h11}; b4.out_ready = 1'b1;
    #1 check("sel_rdy", b4.in_ready, 4'b0100);
    @(posedge clk); #1;
    check("sel_od", b4.out_data, 8'hA5);
    check("sel_os", b4.out_src, 2);
    check("sel_ov", b4.out_valid, 1);

    // Selected channel idle: no grant, register drains.
    @(negedge clk);
    b4.sel = 2'd1; b4.in_valid = 4'b1101;
    #1 check("idle_rdy", b4.in_ready, 0);
    @(posedge clk); #1 check("idle_ov", b4.out_valid, 0);

    // Round robin, all valid, no bubbles.
    @(negedge clk);
    b4.mode = MODE_RR; b4.in_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("rr_os", b4.out_src, i % 4);
      check("rr_ov", b4.out_valid, 1);
    end

    // Move ptr to 1, then check wrap and idle-channel skipping.
    @(negedge clk);
    b4.in_valid = 4'b0001;
    @(posedge clk);
    exp_src = '{3, 0, 3};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      b4.in_valid = 4'b1001;
      #1 check("wrap_rdy", b4.in_ready, 32'(1) << exp_src[k]);
      @(posedge clk); #1 check("wrap_os", b4.out_src, exp_src[k]);
    end

    // Backpressure: holding beat from channel 3, nothing accepted.
    @(negedge clk);
    b4.out_ready = 1'b0; b4.in_valid = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_rdy", b4.in_ready, 0);
      check("bp_od", b4.out_data, 8'h44);
      check("bp_os", b4.out_src, 3);
      @(negedge clk);
    end
    b4.out_ready = 1'b1;
    #1 check("bp_rel_rdy", b4.in_ready, 4'b0001);
    @(posedge clk); #1;
    check("bp_rel_ov", b4.out_valid, 1);
    check("bp_rel_os", b4.out_src, 0);
    check("bp_rel_od", b4.out_data, 8'h11);

    // Asynchronous reset with a beat in flight.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ov", b4.out_valid, 0);
    check("arst_od", b4.out_data, 0);
    check("arst_rdy", b4.in_ready, 0);
    b4.in_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized run on the 3-channel mux against a behavioural model.
    m_ptr = 0; m_ov = 1'b0;
    wait_cnt = '{0, 0, 0};
    for (int cyc = 0; cyc < 1000; cyc++) begin
      @(negedge clk);
      b3.mode      = mode_e'(1'($urandom_range(0, 1)));
      b3.sel       = 2'($urandom_range(0, 3));
      b3.in_valid  = 3'($urandom_range(0, 7));
      b3.in_data   = 24'($urandom);
      b3.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      can = !m_ov || b3.out_ready;
      gv = 1'b0; gi = 0;
      if (b3.mode == MODE_SEL) begin
        if (b3.sel < 3 && b3.in_valid[b3.sel]) begin gv = 1'b1; gi = int'(b3.sel); end
      end else begin
        for (int k = 0; k < 3; k++) begin
          c = (m_ptr + k) % 3;
          if (!gv && b3.in_valid[c]) begin gv = 1'b1; gi = c; end
        end
      end
      exp_rdy = (can && gv) ? (32'(1) << gi) : 32'd0;
      check("rnd_rdy", b3.in_ready, exp_rdy);
      check("rnd_ov", b3.out_valid, m_ov);
      if (m_ov && b3.out_ready) begin
        beat = {22'd0, b3.out_src, b3.out_data};
        if (exp_q.size() == 0) begin
          check("rnd_sb_empty", beat, 32'hFFFF_FFFF);
        end else begin
          front = exp_q.pop_front();
          check("rnd_beat", beat, front);
        end
      end
      for (int ch = 0; ch < 3; ch++) begin
        if (b3.mode == MODE_RR && b3.in_valid[ch]) begin
          if (can && gv && gi != ch) begin
            wait_cnt[ch]++;
            check("rr_fair", 32'(wait_cnt[ch] <= 2), 1);
          end else if (can && gv) begin
            wait_cnt[ch] = 0;
          end
        end else begin
          wait_cnt[ch] = 0;
        end
      end
      if (can && gv) begin
        dat = b3.in_data[gi*8 +: 8];
        exp_q.push_back((32'(gi) << 8) | 32'(dat));
        m_ov = 1'b1;
        if (b3.mode == MODE_RR) m_ptr = (gi == 2) ? 0 : gi + 1;
      end else if (b3.out_ready) begin
        m_ov = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
